// File: rtl/dec2float.sv
// dec2float: converts a decimal value (sign, 32-bit integer part, fraction
// scaled by 1e9) into an IEEE-754 single-precision word.
// The fraction is turned into 40 binary digits by repeated doubling, then
// normalised and packed. The default build truncates the mantissa.
// Optional feature macro: DEC2FLOAT_ROUND_NEAREST_EN selects round-to-nearest-even.
// Either build takes the same number of cycles per conversion.
module dec2float (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] int_dec,
    input  logic [31:0] frac_dec,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_754,
    output logic        i754_overflow
);

    localparam logic [30:0] BILLION = 31'd1_000_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FRAC = 2'd1,
        NORM = 2'd2,
        PACK = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        sign_r;
    logic [23:0] int_r;
    logic        ovf_in_r;
    logic [29:0] rem_r;
    logic [39:0] bits_r;
    logic [5:0]  cnt_r;
    logic [7:0]  exp_r;
    logic [22:0] mant_r;
    logic        inf_r;

    // Position of the most significant set bit (0 when the value is zero).
    function automatic logic [5:0] lead_one(input logic [63:0] v);
        logic [5:0] p;
        p = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) p = 6'(i);
        end
        return p;
    endfunction

`ifdef DEC2FLOAT_ROUND_NEAREST_EN
    // Round-to-nearest-even; returns {exponent[8:0], mantissa[22:0]} with the
    // mantissa carry-out folded into the exponent.
    function automatic logic [31:0] round_nearest_even(input logic [8:0]  e,
                                                       input logic [22:0] m,
                                                       input logic        g,
                                                       input logic        s);
        logic [23:0] sum;
        logic [8:0]  e_out;
        sum   = {1'b0, m} + {23'b0, g & (s | m[0])};
        e_out = sum[23] ? e + 9'd1 : e;
        return {e_out, sum[22:0]};
    endfunction
`endif

    // One restoring step of the decimal-to-binary fraction expansion.
    logic [30:0] r2;
    logic        fbit;
    logic [29:0] rem_nxt;

    // Doubling step: emit one binary fraction digit and the new remainder.
    always_comb begin
        r2      = {rem_r, 1'b0};
        fbit    = (r2 >= BILLION);
        rem_nxt = fbit ? 30'(r2 - BILLION) : r2[29:0];
    end

    // Normalisation of the 64-bit fixed-point value {int[23:0], frac[39:0]}.
    logic [63:0] fixed;
    logic [5:0]  lead;
    logic        is_zero;
    logic [7:0]  exp_nxt;
    logic [22:0] mant_nxt;
    logic        inf_nxt;

`ifdef DEC2FLOAT_ROUND_NEAREST_EN
    logic [87:0] ext;
    logic [87:0] low_mask;
    logic [22:0] mant_t;
    logic        guard;
    logic        sticky;
    logic [8:0]  exp_t;
    logic [31:0] rounded;

    // Leading-one search, guard/sticky extraction and rounding.
    always_comb begin
        fixed    = {int_r, bits_r};
        lead     = lead_one(fixed);
        is_zero  = (fixed == 64'd0);
        // fixed bit i sits at ext bit i+24, so bit lead-24 (guard) is ext[lead]
        ext      = {fixed, 24'b0};
        mant_t   = ext[7'({1'b0, lead}) + 7'd1 +: 23];
        guard    = ext[{1'b0, lead}];
        low_mask = (88'd1 << lead) - 88'd1;
        sticky   = (|(ext & low_mask)) | (rem_r != 30'd0);
        exp_t    = {3'b0, lead} + 9'd87;
        rounded  = round_nearest_even(exp_t, mant_t, guard, sticky);
        exp_nxt  = rounded[30:23];
        mant_nxt = rounded[22:0];
        inf_nxt  = (rounded[31:23] >= 9'd255);
        if (is_zero) begin
            exp_nxt  = 8'd0;
            mant_nxt = 23'd0;
            inf_nxt  = 1'b0;
        end
    end
`else
    logic [86:0] ext;

    // Leading-one search and truncating mantissa extraction.
    always_comb begin
        fixed    = {int_r, bits_r};
        lead     = lead_one(fixed);
        is_zero  = (fixed == 64'd0);
        // fixed bit i sits at ext bit i+23; bits below bit 0 read as zero
        ext      = {fixed, 23'b0};
        mant_nxt = ext[{1'b0, lead} +: 23];
        exp_nxt  = {2'b0, lead} + 8'd87;
        inf_nxt  = 1'b0;
        if (is_zero) begin
            exp_nxt  = 8'd0;
            mant_nxt = 23'd0;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; FRAC lasts exactly 40 cycles (counter 0..39).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FRAC;
            FRAC:    if (cnt_r == 6'd39) state_nxt = NORM;
            NORM:    state_nxt = PACK;
            PACK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture, fraction expansion, normalisation and result packing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r        <= 1'b0;
            int_r         <= 24'd0;
            ovf_in_r      <= 1'b0;
            rem_r         <= 30'd0;
            bits_r        <= 40'd0;
            cnt_r         <= 6'd0;
            exp_r         <= 8'd0;
            mant_r        <= 23'd0;
            inf_r         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result_754    <= 32'd0;
            i754_overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r   <= sign;
                        int_r    <= int_dec[23:0];
                        ovf_in_r <= (int_dec[31:24] != 8'd0) ||
                                    (frac_dec >= 32'd1_000_000_000);
                        rem_r    <= frac_dec[29:0];
                        bits_r   <= 40'd0;
                        cnt_r    <= 6'd0;
                        busy     <= 1'b1;
                    end
                end
                FRAC: begin
                    rem_r  <= rem_nxt;
                    bits_r <= {bits_r[38:0], fbit};
                    cnt_r  <= cnt_r + 6'd1;
                end
                NORM: begin
                    exp_r  <= exp_nxt;
                    mant_r <= mant_nxt;
                    inf_r  <= inf_nxt;
                end
                PACK: begin
                    if (ovf_in_r || inf_r) begin
                        result_754    <= {sign_r, 8'hFF, 23'h0};
                        i754_overflow <= 1'b1;
                    end else begin
                        result_754    <= {sign_r, exp_r, mant_r};
                        i754_overflow <= 1'b0;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
